// File: rtl/fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// fpu_round_pipe : two-stage stallable normalise-and-round FPU back end
// Revision       : 1.0
// ============================================================================
module fpu_round_pipe #(
    parameter int NE   = 8,
    parameter int NF   = 23,
    parameter int SIGW = 52,
    parameter int TAGW = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [NE+1:0]       in_exp,
    input  logic [SIGW-1:0]     in_sig,
    input  logic                in_sticky,
    input  logic                in_invalid,
    input  logic [2:0]          in_frm,
    input  logic [TAGW-1:0]     in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NE+NF:0]      out_res,
    output logic [4:0]          out_flags,
    output logic [TAGW-1:0]     out_tag,
    input  logic                fflags_clr,
    output logic [4:0]          fflags_acc
);

    localparam int EW  = NE + 3;
    localparam int SHW = $clog2(SIGW + 3);

    localparam logic signed [EW-1:0] C_ZERO = '0;
    localparam logic signed [EW-1:0] C_ONE  = EW'(1);
    localparam logic signed [EW-1:0] C_SAT  = EW'(SIGW + 2);
    localparam logic        [EW-1:0] C_EMAX = EW'((1 << NE) - 1);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef struct packed {
        logic            sign;
        logic [EW-1:0]   exp;
        logic [NF:0]     kept;
        logic            guard;
        logic            sticky;
        logic [2:0]      frm;
        logic            invalid;
        logic            tiny;
        logic [TAGW-1:0] tag;
    } s1_t;

    function automatic logic f_plus1(input logic [2:0] frm, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic sticky);
        case (frm)
            RM_RTZ:  f_plus1 = 1'b0;
            RM_RDN:  f_plus1 = sign & (guard | sticky);
            RM_RUP:  f_plus1 = ~sign & (guard | sticky);
            RM_RMM:  f_plus1 = guard;
            default: f_plus1 = guard & (sticky | lsb);
        endcase
    endfunction

    logic            s1_valid_q, s1_valid_d;
    s1_t             s1_q, s1_d;
    logic            out_valid_q, out_valid_d;
    logic [NE+NF:0]  out_res_q, out_res_d;
    logic [4:0]      out_flags_q, out_flags_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic [4:0]      fflags_q, fflags_d;

    logic s2_advance;
    assign s2_advance = ~out_valid_q | out_ready;
    assign in_ready   = ~s1_valid_q | s2_advance;

    // ---------------- stage 1: normalise / align ----------------
    logic [SHW-1:0]        lzc;
    logic [SHW-1:0]        sh;
    logic signed [EW-1:0]  exp_x;
    logic signed [EW-1:0]  eu;
    logic signed [EW-1:0]  e1;
    logic signed [EW-1:0]  rsh_full;
    logic [SIGW-1:0]       norm;
    logic [SIGW-1:0]       aligned;
    logic                  lost;
    logic                  plus1_u;

    always_comb begin
        lzc = SHW'(SIGW);
        for (int i = 0; i < SIGW; i++) begin
            if (in_sig[i]) lzc = SHW'(SIGW - 1 - i);
        end

        exp_x    = {in_exp[NE+1], in_exp};
        eu       = exp_x - EW'(lzc);
        norm     = in_sig << lzc;
        rsh_full = C_ONE - exp_x;
        sh       = '0;
        lost     = 1'b0;
        e1       = C_ONE;

        if (exp_x >= C_ONE) begin
            if (eu >= C_ONE) begin
                aligned = norm;
                e1      = eu;
            end else begin
                // normalising fully would go below the minimum exponent
                sh      = SHW'(exp_x - C_ONE);
                aligned = in_sig << sh;
            end
        end else begin
            sh      = (rsh_full > C_SAT) ? SHW'(C_SAT) : SHW'(rsh_full);
            aligned = in_sig >> sh;
            lost    = |(in_sig & ~({SIGW{1'b1}} << sh));
        end

        // rounding as if the exponent range were unbounded decides tininess
        plus1_u = f_plus1(in_frm, in_sign, norm[SIGW-1-NF], norm[SIGW-2-NF],
                          (|norm[SIGW-3-NF:0]) | in_sticky);

        s1_d       = s1_q;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        if (in_valid && in_ready) begin
            s1_d.sign    = in_sign;
            s1_d.exp     = e1;
            s1_d.kept    = aligned[SIGW-1 -: NF+1];
            s1_d.guard   = aligned[SIGW-2-NF];
            s1_d.sticky  = (|aligned[SIGW-3-NF:0]) | lost | in_sticky;
            s1_d.frm     = in_frm;
            s1_d.invalid = in_invalid;
            s1_d.tiny    = (eu < C_ONE) &
                           ~((eu == C_ZERO) & (&norm[SIGW-1 -: NF+1]) & plus1_u);
            s1_d.tag     = in_tag;
        end
    end

    // ---------------- stage 2: round / pack ----------------
    logic           plus1;
    logic [NF+1:0]  sum;
    logic [EW-1:0]  er;
    logic           nx;
    logic           inf_sel;
    logic [NE+NF:0] res_n;
    logic [4:0]     flags_n;
    logic           hs;

    always_comb begin
        plus1   = f_plus1(s1_q.frm, s1_q.sign, s1_q.kept[0], s1_q.guard, s1_q.sticky);
        sum     = {1'b0, s1_q.kept} + (NF+2)'(plus1);
        er      = s1_q.exp + EW'(sum[NF+1]);
        nx      = s1_q.guard | s1_q.sticky;
        inf_sel = (s1_q.frm == RM_RNE) | (s1_q.frm == RM_RMM) |
                  ((s1_q.frm == RM_RUP) & ~s1_q.sign) |
                  ((s1_q.frm == RM_RDN) & s1_q.sign);

        res_n   = {s1_q.sign, ((sum[NF+1] | sum[NF]) ? er[NE-1:0] : {NE{1'b0}}),
                   sum[NF-1:0]};
        flags_n = {3'b000, nx & s1_q.tiny, nx};

        if (s1_q.invalid) begin
            res_n   = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};
            flags_n = 5'b10000;
        end else if (er >= C_EMAX) begin
            res_n   = inf_sel ? {s1_q.sign, {NE{1'b1}}, {NF{1'b0}}}
                              : {s1_q.sign, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
            flags_n = 5'b00101;
        end

        out_valid_d = s2_advance ? s1_valid_q : out_valid_q;
        out_res_d   = out_res_q;
        out_flags_d = out_flags_q;
        out_tag_d   = out_tag_q;
        if (s2_advance && s1_valid_q) begin
            out_res_d   = res_n;
            out_flags_d = flags_n;
            out_tag_d   = s1_q.tag;
        end

        hs = out_valid_q & out_ready;
        if (hs) fflags_d = fflags_clr ? out_flags_q : (fflags_q | out_flags_q);
        else    fflags_d = fflags_clr ? 5'b00000 : fflags_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
            out_tag_q   <= '0;
            fflags_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
            out_tag_q   <= out_tag_d;
            fflags_q    <= fflags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_res    = out_res_q;
    assign out_flags  = out_flags_q;
    assign out_tag    = out_tag_q;
    assign fflags_acc = fflags_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// tb_fpu_round_pipe : directed bench for the single-precision configuration
// Revision          : 1.0
// ============================================================================
module tb_fpu_round_pipe;

    localparam logic [51:0] SIG_ONE = 52'h8000000000000;
    localparam logic [51:0] SIG_TIE = 52'h8000008000000;
    localparam logic [51:0] SIG_SUB = 52'h8000000000001;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [51:0] in_sig;
    logic        in_sticky;
    logic        in_invalid;
    logic [2:0]  in_frm;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;
    logic        fflags_clr;
    logic [4:0]  fflags_acc;

    int total = 0;
    int bad   = 0;

    logic [31:0] r;
    logic [4:0]  f;
    logic [3:0]  t;
    int          l;

    fpu_round_pipe #(.NE(8), .NF(23), .SIGW(52), .TAGW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_sticky  (in_sticky),
        .in_invalid (in_invalid),
        .in_frm     (in_frm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .fflags_clr (fflags_clr),
        .fflags_acc (fflags_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction into an empty pipe and returns its result.
    task automatic run_one(input logic s, input logic [9:0] e, input logic [51:0] sg,
                           input logic stk, input logic inv, input logic [2:0] rm,
                           input logic [3:0] tg, output logic [31:0] res,
                           output logic [4:0] fl, output logic [3:0] otag, output int lat);
        int wait_c;
        wait_c    = 0;
        out_ready = 1'b1;
        while (!in_ready && wait_c < 10) begin
            @(posedge clk); #1;
            wait_c++;
        end
        in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = sg;
        in_sticky = stk; in_invalid = inv; in_frm = rm; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = out_res;
        fl   = out_flags;
        otag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if (out_res !== 32'h0) begin bad++; $display("FAIL reset_out_res got=%h want=0", out_res); end
        total++; if (out_flags !== 5'b0) begin bad++; $display("FAIL reset_out_flags got=%b want=0", out_flags); end
        total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        total++; if (fflags_acc !== 5'b0) begin bad++; $display("FAIL reset_fflags got=%b want=0", fflags_acc); end
    endtask

    task automatic test_exact_one();
        run_one(1'b0, 10'd127, SIG_ONE, 1'b0, 1'b0, 3'b000, 4'hA, r, f, t, l);
        total++; if (r !== 32'h3F800000) begin bad++; $display("FAIL one_res got=%h want=3f800000", r); end
        total++; if (f !== 5'b00000) begin bad++; $display("FAIL one_flags got=%b want=00000", f); end
        total++; if (t !== 4'hA) begin bad++; $display("FAIL one_tag got=%h want=a", t); end
        total++; if (l !== 2) begin bad++; $display("FAIL one_latency got=%0d want=2", l); end
    endtask

    task automatic test_tie();
        logic [2:0]  rm  [3] = '{3'b000, 3'b011, 3'b100};
        logic [31:0] exp [3] = '{32'h3F800000, 32'h3F800001, 32'h3F800001};
        for (int i = 0; i < 3; i++) begin
            run_one(1'b0, 10'd127, SIG_TIE, 1'b0, 1'b0, rm[i], 4'h1, r, f, t, l);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL tie_res rm=%0d got=%h want=%h", rm[i], r, exp[i]); end
            total++; if (f !== 5'b00001) begin bad++; $display("FAIL tie_flags rm=%0d got=%b want=00001", rm[i], f); end
        end
        // input sticky alone must push RUP to the next ulp
        run_one(1'b0, 10'd127, SIG_ONE, 1'b1, 1'b0, 3'b011, 4'h2, r, f, t, l);
        total++; if (r !== 32'h3F800001) begin bad++; $display("FAIL sticky_res got=%h want=3f800001", r); end
        total++; if (f !== 5'b00001) begin bad++; $display("FAIL sticky_flags got=%b want=00001", f); end
    endtask

    task automatic test_overflow();
        logic        sg  [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  rm  [3] = '{3'b000, 3'b001, 3'b011};
        logic [31:0] exp [3] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF};
        for (int i = 0; i < 3; i++) begin
            run_one(sg[i], 10'd255, SIG_ONE, 1'b0, 1'b0, rm[i], 4'h3, r, f, t, l);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL ovf_res case=%0d got=%h want=%h", i, r, exp[i]); end
            total++; if (f !== 5'b00101) begin bad++; $display("FAIL ovf_flags case=%0d got=%b want=00101", i, f); end
        end
    endtask

    task automatic test_subnormal();
        // (2^51+1)/2^51 * 2^-137 truncated: 2^-137 = 2^12 * 2^-149
        run_one(1'b0, 10'h3F6, SIG_SUB, 1'b0, 1'b0, 3'b001, 4'h4, r, f, t, l);
        total++; if (r !== 32'h00001000) begin bad++; $display("FAIL sub_res got=%h want=00001000", r); end
        total++; if (f !== 5'b00011) begin bad++; $display("FAIL sub_flags got=%b want=00011", f); end
        run_one(1'b0, 10'h3EA, SIG_ONE, 1'b0, 1'b0, 3'b000, 4'h5, r, f, t, l);
        total++; if (r !== 32'h00000001) begin bad++; $display("FAIL minsub_res got=%h want=00000001", r); end
        total++; if (f !== 5'b00000) begin bad++; $display("FAIL minsub_flags got=%b want=00000", f); end
        run_one(1'b1, 10'd127, 52'h0, 1'b0, 1'b0, 3'b000, 4'h6, r, f, t, l);
        total++; if (r !== 32'h80000000) begin bad++; $display("FAIL zero_res got=%h want=80000000", r); end
        total++; if (f !== 5'b00000) begin bad++; $display("FAIL zero_flags got=%b want=00000", f); end
    endtask

    task automatic test_invalid();
        run_one(1'b1, 10'd200, SIG_TIE, 1'b0, 1'b1, 3'b000, 4'h7, r, f, t, l);
        total++; if (r !== 32'h7FC00000) begin bad++; $display("FAIL nan_res got=%h want=7fc00000", r); end
        total++; if (f !== 5'b10000) begin bad++; $display("FAIL nan_flags got=%b want=10000", f); end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          next_tag;
        int          got;
        int          accepted;
        logic        acc_now;
        logic [31:0] held;
        cyc = 0; next_tag = 0; got = 0; accepted = 0; held = '0;
        in_valid = 1'b1; in_sign = 1'b0; in_sig = SIG_ONE; in_sticky = 1'b0;
        in_invalid = 1'b0; in_frm = 3'b000; in_tag = 4'h0; in_exp = 10'd127;
        while (got < 5 && cyc < 40) begin
            out_ready = (cyc >= 4);
            #0;
            if (cyc == 2) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
                total++; if (accepted !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", accepted); end
                held = out_res;
            end
            if (cyc == 3) begin
                total++; if (out_valid !== 1'b1 || out_tag !== 4'h0) begin bad++; $display("FAIL bp_hold_tag got=%0b/%h want=1/0", out_valid, out_tag); end
                total++; if (out_res !== held) begin bad++; $display("FAIL bp_hold_res got=%h want=%h", out_res, held); end
            end
            acc_now = in_valid & in_ready;
            if (out_valid && out_ready) begin
                total++; if (out_tag !== 4'(got) || out_res !== 32'h3F800000 + (got << 23)) begin
                    bad++; $display("FAIL bp_order got=%h/%h want=%h/%h", out_tag, out_res, 4'(got), 32'h3F800000 + (got << 23));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                accepted++;
                next_tag++;
                if (next_tag == 5) in_valid = 1'b0;
                else begin
                    in_tag = 4'(next_tag);
                    in_exp = 10'd127 + 10'(next_tag);
                end
            end
        end
        total++; if (got !== 5) begin bad++; $display("FAIL bp_count got=%0d want=5", got); end
        repeat (3) @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0b want=0", out_valid); end
    endtask

    task automatic test_fflags();
        int wait_c;
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        total++; if (fflags_acc !== 5'b00000) begin bad++; $display("FAIL acc_clear got=%b want=00000", fflags_acc); end
        run_one(1'b0, 10'd127, SIG_TIE, 1'b0, 1'b0, 3'b000, 4'h1, r, f, t, l);
        run_one(1'b0, 10'd127, SIG_TIE, 1'b0, 1'b0, 3'b011, 4'h2, r, f, t, l);
        total++; if (fflags_acc !== 5'b00001) begin bad++; $display("FAIL acc_nx got=%b want=00001", fflags_acc); end
        run_one(1'b0, 10'd127, SIG_ONE, 1'b0, 1'b1, 3'b000, 4'h3, r, f, t, l);
        total++; if (fflags_acc !== 5'b10001) begin bad++; $display("FAIL acc_nv got=%b want=10001", fflags_acc); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd255; in_sig = SIG_ONE;
        in_sticky = 1'b0; in_invalid = 1'b0; in_frm = 3'b000; in_tag = 4'h4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_c = 0;
        while (!out_valid && wait_c < 20) begin
            @(posedge clk); #1;
            wait_c++;
        end
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        total++; if (fflags_acc !== 5'b00101) begin bad++; $display("FAIL acc_clr_hs got=%b want=00101", fflags_acc); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_sig = SIG_ONE;
        in_sticky = 1'b0; in_invalid = 1'b0; in_frm = 3'b000; in_tag = 4'h9;
        @(posedge clk); #1;
        in_tag = 4'hB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_tag !== 4'h9) begin bad++; $display("FAIL stall_pre got=%0b/%h want=1/9", out_valid, out_tag); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%0b want=0", out_valid); end
        total++; if (out_res !== 32'h0 || out_tag !== 4'h0 || out_flags !== 5'b0) begin
            bad++; $display("FAIL mrst_data got=%h/%h/%b want=0/0/0", out_res, out_tag, out_flags);
        end
        total++; if (fflags_acc !== 5'b0) begin bad++; $display("FAIL mrst_fflags got=%b want=00000", fflags_acc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%0b want=1", in_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_after got=%0b want=0", out_valid); end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sig = '0;
        in_sticky = 1'b0; in_invalid = 1'b0; in_frm = '0; in_tag = '0;
        out_ready = 1'b1; fflags_clr = 1'b0;
        repeat (3) @(posedge clk); #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_exact_one();
        test_tie();
        test_overflow();
        test_subnormal();
        test_invalid();
        test_back_to_back();
        test_fflags();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
